mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter RAM_AW, default 17: RAM address width.
REQ-002 SHALL have port clk, in, 1: single clock, rising edge.
REQ-003 SHALL have port rst, in, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port if_req, in, 1: fetch request, held until if_done.
REQ-005 SHALL have port if_addr, in, 32: fetch address.
REQ-006 SHALL have port if_done, out, 1: one-cycle fetch-complete pulse.
REQ-007 SHALL have port if_data, out, 32: fetched word, little-endian.
REQ-008 SHALL have port mem_req, in, 1: load/store request, held until mem_done.
REQ-009 SHALL have port mem_we, in, 1: 1 = store.
REQ-010 SHALL have port mem_len, in, 2: 0 byte, 1 half, 2 word, 3 treated as word.
REQ-011 SHALL have port mem_addr, in, 32: data address.
REQ-012 SHALL have port mem_wdata, in, 32: store data, low bytes used.
REQ-013 SHALL have port mem_done, out, 1: one-cycle access-complete pulse.
REQ-014 SHALL have port mem_rdata, out, 32: load data, zero-extended.
REQ-015 SHALL have port flush, in, 1: branch redirect; aborts an in-flight fetch.
REQ-016 SHALL have ports ram_a, out, RAM_AW; ram_dout, out, 8; ram_wr, out, 1; ram_din, in, 8: byte-wide RAM, read data valid one cycle after address.
REQ-017 SHALL have ports stall_if, out, 1 and stall_mem, out, 1: stall requests to the stall controller.

Function
REQ-018 SHALL implement FSM IDLE, IF_RD, MEM_RD, MEM_WR, DONE, plus a byte counter cnt (0..4) and latched base address, length and grant owner.
REQ-019 IDLE SHALL grant mem_req over if_req (fixed priority); it SHALL enter MEM_WR if mem_we, else MEM_RD, else IF_RD if if_req, else stay IDLE, with cnt=0.
REQ-020 SHALL set n = 4 for fetch and 1/2/4 for mem_len 0/1/2(3).
REQ-021 In read states SHALL drive ram_a = (base+cnt) truncated to RAM_AW while cnt<n, and capture ram_din into byte lane cnt-1 while cnt>=1.
REQ-022 Read states SHALL last n+1 cycles and then enter DONE; fetch request to if_done latency SHALL be 6 cycles.
REQ-023 MEM_WR SHALL drive ram_wr=1, ram_a=base+cnt and ram_dout=mem_wdata byte cnt for n cycles, then enter DONE.
REQ-024 DONE SHALL last exactly one cycle, assert if_done or mem_done for the owner with data stable, then return to IDLE without granting in that cycle.
REQ-025 Unread upper bytes of mem_rdata SHALL be 0.
REQ-026 Address arithmetic SHALL wrap modulo 2^RAM_AW; e.g. base 0x1FFFF with cnt 1 gives 0x00000.
REQ-027 flush=1 in IF_RD SHALL return to IDLE next cycle with no if_done; flush SHALL NOT affect MEM_RD, MEM_WR or DONE.
REQ-028 ram_wr SHALL be 0 in every state except MEM_WR.
REQ-029 stall_if SHALL equal if_req & ~if_done, and stall_mem SHALL equal mem_req & ~mem_done, both combinationally.
REQ-030 A request arriving while busy SHALL wait; requests changed before done SHALL cause undefined results.

Reset
REQ-031 rst=0 SHALL asynchronously force state IDLE, cnt 0, ram_wr 0, ram_a 0, ram_dout 0, done pulses 0 and data outputs 0.
REQ-032 Reset mid-store SHALL leave already-written bytes in RAM; no rollback is required.

Structure
REQ-033 State encoding, length codes (LEN_B/LEN_H/LEN_W) and ZeroWord SHALL live in the shared defines package.
REQ-034 Byte assembly and byte selection SHALL be inline; no sub-module is required.

Verification
REQ-035 Fetch 0x100 with RAM bytes 13,05,00,00 -> if_done in cycle 6, if_data=0x00000513, ram_wr never 1.
REQ-036 if_req and mem_req(lw 0x200) in the same cycle -> load is served first; fetch starts the cycle after mem_done.
REQ-037 sh 0x204 with wdata 0xAABBCCDD -> ram_wr for 2 cycles writing DD@0x204 and CC@0x205, then mem_done.
REQ-038 lb 0x1FFFF then lw 0x1FFFF -> mem_rdata=0x000000XX, then the word read from 0x1FFFF, 0x0, 0x1, 0x2.
REQ-039 flush at cnt=2 of a fetch -> IDLE next cycle, no if_done; a new fetch to 0x300 completes normally.
REQ-040 rst low during MEM_WR cnt=1 -> ram_wr=0 immediately, state IDLE, mem_done never pulses.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
//   Shared definitions for the byte-serial memory controller:
//     state_t    - controller FSM state encoding
//     owner_t    - which requester a transaction belongs to
//     LEN_B/H/W  - mem_len codes (code 3 behaves like LEN_W)
//     ZeroWord   - all-zero data word used to clear assembly registers
//     len_bytes  - byte count for a mem_len code
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IF_RD  = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  localparam logic [1:0]  LEN_B    = 2'd0;
  localparam logic [1:0]  LEN_H    = 2'd1;
  localparam logic [1:0]  LEN_W    = 2'd2;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Number of bytes moved for a load/store length code.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      LEN_B:   n = 3'd1;
      LEN_H:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//   Arbitrates an instruction-fetch port and a load/store port onto a single
//   byte-wide synchronous RAM. Words are moved one byte per cycle,
//   little-endian. The load/store port has fixed priority over fetch.
//
// Handshake (both request ports): the requester raises *_req with its
// address/controls and holds all of them stable until the matching *_done
// pulse (one cycle); it may drop *_req in the cycle after *_done. A request
// raised while the controller is busy simply waits. stall_* is high while a
// request is pending and not yet completing.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   if_req/if_addr    fetch request and byte address
//   if_done/if_data   fetch-complete pulse and fetched word
//   mem_req/mem_we    load/store request, 1 = store
//   mem_len/mem_addr  size code (LEN_B/H/W) and byte address
//   mem_wdata         store data (low bytes used)
//   mem_done/mem_rdata access-complete pulse and zero-extended load data
//   flush             aborts an in-flight fetch
//   ram_a/ram_dout/ram_wr/ram_din  byte RAM port, read data one cycle late
//   stall_if/stall_mem stall requests
//   dbg_state         current FSM state, for observation only
// -----------------------------------------------------------------------------
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  input  logic              flush,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din,
  output logic              stall_if,
  output logic              stall_mem,
  output state_t            dbg_state
);

  state_t              state_q,     state_d;
  logic [2:0]          cnt_q,       cnt_d;
  logic [2:0]          n_q,         n_d;
  logic [RAM_AW-1:0]   base_q,      base_d;
  owner_t              owner_q,     owner_d;
  logic [31:0]         if_data_q,   if_data_d;
  logic [31:0]         mem_rdata_q, mem_rdata_d;

  // Byte lane filled by the RAM data returning this cycle: the address
  // for lane k was presented in the previous cycle, when cnt was k.
  logic [1:0]          lane;
  logic [RAM_AW-1:0]   cur_addr;

  // Address bits above the RAM width are intentionally ignored.
  generate
    if (RAM_AW < 32) begin : g_unused
      logic unused_addr_bits;
      assign unused_addr_bits = ^{if_addr[31:RAM_AW], mem_addr[31:RAM_AW]};
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    base_d      = base_q;
    owner_d     = owner_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    ram_a       = '0;
    ram_dout    = 8'h00;
    ram_wr      = 1'b0;
    lane        = cnt_q[1:0] - 2'd1;
    // Sum is truncated to RAM_AW bits, so accesses wrap around the RAM.
    cur_addr    = base_q + RAM_AW'(cnt_q);

    case (state_q)
      ST_IDLE: begin
        cnt_d = 3'd0;
        if (mem_req) begin
          owner_d = OWN_MEM;
          base_d  = mem_addr[RAM_AW-1:0];
          n_d     = len_bytes(mem_len);
          if (mem_we) begin
            state_d = ST_MEM_WR;
          end else begin
            // Clearing here leaves unread upper bytes at zero.
            mem_rdata_d = ZeroWord;
            state_d     = ST_MEM_RD;
          end
        end else if (if_req) begin
          owner_d   = OWN_IF;
          base_d    = if_addr[RAM_AW-1:0];
          n_d       = 3'd4;
          if_data_d = ZeroWord;
          state_d   = ST_IF_RD;
        end
      end

      ST_IF_RD, ST_MEM_RD: begin
        if (state_q == ST_IF_RD && flush) begin
          // Redirect: drop the fetch without completing it.
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_q < n_q) begin
            ram_a = cur_addr;
          end
          if (cnt_q != 3'd0) begin
            if (owner_q == OWN_IF) begin
              if_data_d[{lane, 3'b000} +: 8] = ram_din;
            end else begin
              mem_rdata_d[{lane, 3'b000} +: 8] = ram_din;
            end
          end
          // n address cycles plus one trailing capture cycle.
          if (cnt_q == n_q) begin
            state_d = ST_DONE;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      ST_MEM_WR: begin
        ram_wr   = 1'b1;
        ram_a    = cur_addr;
        ram_dout = mem_wdata[{cnt_q[1:0], 3'b000} +: 8];
        if (cnt_q == n_q - 3'd1) begin
          state_d = ST_DONE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      ST_DONE: begin
        // No capture happens here, so data outputs stay stable during
        // the done pulse. No new grant is taken in this cycle.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      base_q      <= '0;
      owner_q     <= OWN_IF;
      if_data_q   <= ZeroWord;
      mem_rdata_q <= ZeroWord;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      base_q      <= base_d;
      owner_q     <= owner_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign if_done   = (state_q == ST_DONE) && (owner_q == OWN_IF);
  assign mem_done  = (state_q == ST_DONE) && (owner_q == OWN_MEM);
  assign if_data   = if_data_q;
  assign mem_rdata = mem_rdata_q;
  assign stall_if  = if_req & ~if_done;
  assign stall_mem = mem_req & ~mem_done;
  assign dbg_state = state_q;

endmodule
